// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and
// default geometry constants.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_state_e;

   localparam int PIPE_STAGES  = 4;
   localparam int PIPE_MEM_IDX = PIPE_STAGES - 2;
   localparam int PIPE_RA_W    = 4;
   localparam int PIPE_CNT_W   = 16;

endpackage

// File: rtl/pipe_ctrl_chk.sv
// Simulation checks for pipe_ctrl: a taken redirect must resolve before the memory stage.
module pipe_ctrl_chk #(
   parameter int STAGES  = 4,
   parameter int MEM_IDX = STAGES - 2
) (
   input logic                      clk,
   input logic                      rst_n,
   input logic                      redirect,
   input logic                      d_stall,
   input logic                      halted,
   input logic [$clog2(STAGES)-1:0] redirect_stage
);

   a_redirect_stage_legal: assert property (
      @(posedge clk) disable iff (!rst_n)
      (redirect && !d_stall && !halted) |-> (int'(redirect_stage) < MEM_IDX)
   );

endmodule

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: clear wins, increment stops at the ceiling
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {W{1'b0}};
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline hazard controller: stall/bubble/redirect arbitration,
// per-register valid and halt tracking, halt drain FSM and stall counter.
module pipe_ctrl import pipe_pkg::*; #(
   parameter int STAGES  = PIPE_STAGES,
   parameter int MEM_IDX = STAGES - 2,
   parameter int RA_W    = PIPE_RA_W,
   parameter int CNT_W   = PIPE_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_rdy,
   input  logic                      d_req,
   input  logic                      d_rdy,
   input  logic [RA_W-1:0]           id_src0,
   input  logic [RA_W-1:0]           id_src1,
   input  logic [1:0]                id_src_vld,
   input  logic                      ex_is_load,
   input  logic [RA_W-1:0]           ex_dst,
   input  logic                      redirect,
   input  logic [$clog2(STAGES)-1:0] redirect_stage,
   input  logic                      hlt_id,
   output logic                      pc_stall,
   output logic                      pc_redirect,
   output logic [STAGES-1:0]         stall,
   output logic [STAGES-1:0]         bubble,
   output logic [STAGES-1:0]         valid,
   output logic                      hlt,
   output logic [1:0]                state,
   output logic [CNT_W-1:0]          stall_cnt
);

   pipe_state_e       state_q;
   logic              hlt_q;
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] tag_q, tag_d;
   logic              d_stall, lu_stall, i_stall, src_hit, cnt_inc;

   assign d_stall  = d_req & ~d_rdy;
   assign src_hit  = (id_src_vld[0] & (id_src0 == ex_dst)) |
                     (id_src_vld[1] & (id_src1 == ex_dst));
   assign lu_stall = ex_is_load & valid_q[1] & src_hit;
   assign i_stall  = ~i_rdy;

   // hazard arbitration: d_stall > redirect > load-use > fetch miss; DRAIN overlays fetch suppression
   always_comb begin
      pc_stall    = 1'b0;
      pc_redirect = 1'b0;
      stall       = {STAGES{1'b0}};
      bubble      = {STAGES{1'b0}};
      if (state_q == HALTED) begin
         stall    = {STAGES{1'b1}};
         pc_stall = 1'b1;
      end else begin
         if (d_stall) begin
            for (int k = 0; k <= MEM_IDX; k++) stall[k] = 1'b1;
            bubble[MEM_IDX+1] = 1'b1;
            pc_stall          = 1'b1;
         end else if (redirect) begin
            pc_redirect = 1'b1;
            for (int k = 0; k < STAGES; k++) bubble[k] = (k <= int'(redirect_stage));
         end else if (lu_stall) begin
            pc_stall  = 1'b1;
            stall[0]  = 1'b1;
            bubble[1] = 1'b1;
         end else if (i_stall) begin
            pc_stall  = 1'b1;
            bubble[0] = 1'b1;
         end else begin
            pc_stall = 1'b0;
         end
         pc_stall  = pc_stall  | (state_q == DRAIN);
         bubble[0] = bubble[0] | (state_q == DRAIN);
      end
   end

   // valid and halt tags advance together: hold on stall, clear on bubble, else shift in
   always_comb begin
      valid_d = (valid_q & stall) |
                ({valid_q[STAGES-2:0], 1'b1} & ~stall & ~bubble);
      tag_d   = (tag_q & stall) |
                ({tag_q[STAGES-2:0], hlt_id} & ~stall & ~bubble);
   end

   // halt FSM with registered pipeline occupancy and halt flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         hlt_q   <= 1'b0;
         valid_q <= {STAGES{1'b0}};
         tag_q   <= {STAGES{1'b0}};
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         case (state_q)
            RUN: begin
               if (hlt_id && valid_q[0] && !bubble[1] && !stall[0]) state_q <= DRAIN;
            end
            DRAIN: begin
               if (tag_d[STAGES-1] && valid_d[STAGES-1]) begin
                  state_q <= HALTED;
                  hlt_q   <= 1'b1;
               end else if (tag_d == {STAGES{1'b0}}) begin
                  state_q <= RUN;
               end
            end
            HALTED:  state_q <= HALTED;
            default: state_q <= RUN;
         endcase
      end
   end

   assign cnt_inc = (state_q == RUN) & pc_stall & ~pc_redirect;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .clr   (1'b0),
      .cnt   (stall_cnt)
   );

   pipe_ctrl_chk #(.STAGES(STAGES), .MEM_IDX(MEM_IDX)) u_chk (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect       (redirect),
      .d_stall        (d_stall),
      .halted         (state_q == HALTED),
      .redirect_stage (redirect_stage)
   );

   assign valid = valid_q;
   assign hlt   = hlt_q;
   assign state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a vector-level reference model.
module tb_pipe_ctrl;

   localparam int STAGES = 4;
   localparam int MEM_IDX = 2;
   localparam int RA_W = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic i_rdy, d_req, d_rdy, ex_is_load, redirect, hlt_id;
   logic [RA_W-1:0] id_src0, id_src1, ex_dst;
   logic [1:0] id_src_vld, redirect_stage;
   logic pc_stall, pc_redirect, hlt;
   logic [STAGES-1:0] stall, bubble, valid;
   logic [1:0] state;
   logic [CNT_W-1:0] stall_cnt;

   always #5 clk = ~clk;

   pipe_ctrl #(.STAGES(STAGES), .MEM_IDX(MEM_IDX), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .i_rdy(i_rdy), .d_req(d_req), .d_rdy(d_rdy),
      .id_src0(id_src0), .id_src1(id_src1), .id_src_vld(id_src_vld),
      .ex_is_load(ex_is_load), .ex_dst(ex_dst), .redirect(redirect),
      .redirect_stage(redirect_stage), .hlt_id(hlt_id),
      .pc_stall(pc_stall), .pc_redirect(pc_redirect), .stall(stall), .bubble(bubble),
      .valid(valid), .hlt(hlt), .state(state), .stall_cnt(stall_cnt)
   );

   int n_tests = 0;
   int n_fail = 0;

   // reference model state
   bit [3:0] m_valid, m_tag, e_stall, e_bub;
   bit e_pcst, e_pcred, m_hlt;
   int m_state, m_cnt;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 4'd0; m_tag = 4'd0; m_hlt = 1'b0; m_state = 0; m_cnt = 0;
   endtask

   task automatic model_comb();
      bit d_st, lu;
      d_st = d_req && !d_rdy;
      lu = ex_is_load && m_valid[1] &&
           ((id_src_vld[0] && id_src0 == ex_dst) || (id_src_vld[1] && id_src1 == ex_dst));
      e_stall = 4'd0; e_bub = 4'd0; e_pcst = 1'b0; e_pcred = 1'b0;
      if (m_state == 2) begin
         e_stall = 4'hF;
         e_pcst = 1'b1;
      end else begin
         if (d_st) begin
            e_stall = 4'((1 << (MEM_IDX + 1)) - 1);
            e_bub = 4'(1 << (MEM_IDX + 1));
            e_pcst = 1'b1;
         end else if (redirect) begin
            e_pcred = 1'b1;
            e_bub = 4'((2 << redirect_stage) - 1);
         end else if (lu) begin
            e_pcst = 1'b1; e_stall = 4'd1; e_bub = 4'd2;
         end else if (!i_rdy) begin
            e_pcst = 1'b1; e_bub = 4'd1;
         end
         if (m_state == 1) begin
            e_pcst = 1'b1;
            e_bub = e_bub | 4'd1;
         end
      end
   endtask

   task automatic model_seq();
      bit [3:0] nv, nt;
      nv = (m_valid & e_stall) | (((m_valid << 1) | 4'd1) & ~e_stall & ~e_bub);
      nt = (m_tag & e_stall) | (((m_tag << 1) | {3'd0, hlt_id}) & ~e_stall & ~e_bub);
      if (m_state == 0 && e_pcst && !e_pcred && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      case (m_state)
         0: if (hlt_id && m_valid[0] && !e_bub[1] && !e_stall[0]) m_state = 1;
         1: begin
            if (nt[3] && nv[3]) begin
               m_state = 2; m_hlt = 1'b1;
            end else if (nt == 4'd0) begin
               m_state = 0;
            end
         end
         default: ;
      endcase
      m_valid = nv; m_tag = nt;
   endtask

   task automatic compare_all();
      chk_eq("pc_stall", pc_stall, e_pcst);
      chk_eq("pc_redirect", pc_redirect, e_pcred);
      chk_eq("stall", stall, e_stall);
      chk_eq("bubble", bubble, e_bub);
      chk_eq("valid", valid, m_valid);
      chk_eq("hlt", hlt, m_hlt);
      chk_eq("state", state, m_state);
      chk_eq("stall_cnt", stall_cnt, m_cnt);
   endtask

   // one clock: compare mid-cycle, then advance model on the edge
   task automatic cyc();
      #1;
      model_comb();
      compare_all();
      @(posedge clk);
      model_seq();
      #1;
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk_eq("rst_valid", valid, 0);
      chk_eq("rst_hlt", hlt, 0);
      chk_eq("rst_state", state, 0);
      chk_eq("rst_cnt", stall_cnt, 0);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic set_idle();
      i_rdy = 1'b1; d_req = 1'b0; d_rdy = 1'b1; id_src0 = 4'd0; id_src1 = 4'd0;
      id_src_vld = 2'd0; ex_is_load = 1'b0; ex_dst = 4'd0; redirect = 1'b0;
      redirect_stage = 2'd0; hlt_id = 1'b0;
   endtask

   task automatic rand_in();
      i_rdy = ($urandom_range(0, 9) < 8);
      d_req = ($urandom_range(0, 3) == 0);
      d_rdy = ($urandom_range(0, 1) == 1);
      id_src0 = 4'($urandom_range(0, 3));
      id_src1 = 4'($urandom_range(0, 3));
      id_src_vld = 2'($urandom_range(0, 3));
      ex_is_load = ($urandom_range(0, 1) == 1);
      ex_dst = 4'($urandom_range(0, 3));
      redirect = ($urandom_range(0, 9) == 0);
      redirect_stage = 2'($urandom_range(0, 1));
      hlt_id = ($urandom_range(0, 39) == 0);
   endtask

   initial begin
      int n;
      int halted_cyc;
      rst_n = 1'b0;
      set_idle();
      model_reset();
      #12;
      chk_eq("por_valid", valid, 0);
      chk_eq("por_state", state, 0);
      chk_eq("por_hlt", hlt, 0);
      chk_eq("por_cnt", stall_cnt, 0);
      rst_n = 1'b1;

      // fill: first fetch lands on the first clock after release
      cyc();
      chk_eq("first_fetch", valid, 4'b0001);
      repeat (3) cyc();
      chk_eq("filled", valid, 4'b1111);

      // data miss for three cycles
      d_req = 1'b1; d_rdy = 1'b0;
      repeat (3) begin
         #1;
         chk_eq("dmiss_stall", stall, 4'b0111);
         chk_eq("dmiss_bubble", bubble, 4'b1000);
         chk_eq("dmiss_pcst", pc_stall, 1);
         cyc();
      end
      chk_eq("dmiss_v3", valid[3], 0);
      chk_eq("dmiss_cnt", stall_cnt, 3);
      d_rdy = 1'b1;
      cyc();
      set_idle();

      // load-use
      ex_is_load = 1'b1; ex_dst = 4'd5; id_src0 = 4'd5; id_src_vld = 2'b01;
      #1;
      chk_eq("lu_stall", stall, 4'b0001);
      chk_eq("lu_bubble", bubble, 4'b0010);
      cyc();
      ex_is_load = 1'b0;
      #1;
      chk_eq("lu_release", stall, 4'b0000);
      cyc();

      // branch overriding a simultaneous load-use
      ex_is_load = 1'b1; redirect = 1'b1; redirect_stage = 2'd1;
      #1;
      chk_eq("br_redirect", pc_redirect, 1);
      chk_eq("br_bubble", bubble, 4'b0011);
      chk_eq("br_stall", stall, 4'b0000);
      cyc();
      set_idle();
      chk_eq("br_valid01", valid[1:0], 2'b00);

      // redirect held during a data miss
      d_req = 1'b1; d_rdy = 1'b0; redirect = 1'b1; redirect_stage = 2'd1;
      repeat (2) begin
         #1;
         chk_eq("dmiss_redir", pc_redirect, 0);
         cyc();
      end
      d_rdy = 1'b1;
      #1;
      chk_eq("redir_after", pc_redirect, 1);
      cyc();
      set_idle();

      // halt drains to HALTED
      cyc();
      hlt_id = 1'b1;
      cyc();
      hlt_id = 1'b0;
      chk_eq("halt_drain", state, 1);
      n = 0;
      while (hlt !== 1'b1 && n < 10) begin
         cyc();
         n++;
      end
      chk_eq("halt_latency", n, 3);
      chk_eq("halted_state", state, 2);
      repeat (5) begin
         rand_in();
         cyc();
      end
      chk_eq("halted_hold", state, 2);
      do_reset();
      set_idle();
      cyc();
      chk_eq("post_halt_fetch", valid, 4'b0001);

      // halt killed by a redirect during drain
      hlt_id = 1'b1;
      cyc();
      chk_eq("kill_drain", state, 1);
      hlt_id = 1'b0; redirect = 1'b1; redirect_stage = 2'd1;
      cyc();
      chk_eq("kill_run", state, 0);
      set_idle();

      // saturation of the stall counter, then async reset mid-run
      do_reset();
      i_rdy = 1'b0;
      repeat (20) cyc();
      chk_eq("sat_cnt", stall_cnt, 15);
      do_reset();
      set_idle();

      // random traffic
      halted_cyc = 0;
      for (int i = 0; i < 800; i++) begin
         rand_in();
         cyc();
         if (m_state == 2) halted_cyc++;
         if (halted_cyc > 4 || $urandom_range(0, 99) == 0) begin
            halted_cyc = 0;
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
